// File: rtl/button_menu_fsm_if.sv
// Button/menu/action bus for button_menu_fsm.
//   b_prev, b_next, b_sel : toggled lines from the debounced button controllers
//   action_ready          : game core accepts the pending action
//   menu_active           : menu open (state not IDLE)
//   cursor                : current menu index
//   action_valid/_id      : pending action handshake towards the game core
// master: the menu controller; slave: the buttons/game-core side.
interface button_menu_fsm_if;
  logic       b_prev;
  logic       b_next;
  logic       b_sel;
  logic       action_ready;
  logic       menu_active;
  logic [2:0] cursor;
  logic       action_valid;
  logic [2:0] action_id;

  modport master (
    input  b_prev, b_next, b_sel, action_ready,
    output menu_active, cursor, action_valid, action_id
  );

  modport slave (
    output b_prev, b_next, b_sel, action_ready,
    input  menu_active, cursor, action_valid, action_id
  );
endinterface

// File: rtl/button_menu_fsm.sv
// Menu navigation controller fed by three toggle-per-press button lines.
// Level changes become one-cycle events, which move a wrapping cursor, close
// the menu after TIMEOUT_CYCLES idle cycles in BROWSE, and issue the selected
// index to the game core over a valid/ready handshake.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : button_menu_fsm_if.master (buttons in, menu/action outputs)
module button_menu_fsm #(
  parameter int unsigned NUM_ITEMS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  button_menu_fsm_if.master      bus
);

  localparam logic [2:0]  LAST_ITEM = 3'(NUM_ITEMS - 1);
  localparam logic [23:0] TO_LAST   = 24'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BROWSE  = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [2:0]  cursor_q, cursor_n;
  logic        valid_q, valid_n;
  logic [2:0]  id_q, id_n;
  logic [23:0] cnt_q, cnt_n;

  logic armed;
  logic p_prev, p_next, p_sel;
  logic e_prev, e_next, e_sel;

  // Previous-value registers always follow the lines, including while
  // unarmed and in PENDING, so nothing stale fires later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      p_prev <= 1'b0;
      p_next <= 1'b0;
      p_sel  <= 1'b0;
    end else begin
      armed  <= 1'b1;
      p_prev <= bus.b_prev;
      p_next <= bus.b_next;
      p_sel  <= bus.b_sel;
    end
  end

  // Unarmed cycle right after reset: a line already high must not count.
  always_comb begin
    e_prev = armed & (bus.b_prev ^ p_prev);
    e_next = armed & (bus.b_next ^ p_next);
    e_sel  = armed & (bus.b_sel  ^ p_sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cursor_q <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state    <= state_n;
      cursor_q <= cursor_n;
      valid_q  <= valid_n;
      id_q     <= id_n;
      cnt_q    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cursor_n = cursor_q;
    valid_n  = valid_q;
    id_n     = id_q;
    cnt_n    = cnt_q;

    unique case (state)
      IDLE: begin
        // Waking event is consumed: no move, no select.
        if (e_prev || e_next || e_sel) begin
          state_n  = BROWSE;
          cursor_n = '0;
          cnt_n    = '0;
        end
      end

      BROWSE: begin
        // Any event, including a discarded prev+next pair, beats the timeout.
        if (e_sel) begin
          state_n = PENDING;
          id_n    = cursor_q;
          valid_n = 1'b1;
          cnt_n   = '0;
        end else if (e_prev && e_next) begin
          cnt_n = '0;
        end else if (e_next) begin
          cursor_n = (cursor_q == LAST_ITEM) ? '0 : cursor_q + 3'd1;
          cnt_n    = '0;
        end else if (e_prev) begin
          cursor_n = (cursor_q == '0) ? LAST_ITEM : cursor_q - 3'd1;
          cnt_n    = '0;
        end else if (cnt_q == TO_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 24'd1;
        end
      end

      PENDING: begin
        cnt_n = '0;
        if (bus.action_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.menu_active  = (state != IDLE);
  assign bus.cursor       = cursor_q;
  assign bus.action_valid = valid_q;
  assign bus.action_id    = id_q;

endmodule

// File: tb/tb_button_menu_fsm.sv
module tb_button_menu_fsm;

  logic clk;
  logic rst_n;

  button_menu_fsm_if bus ();

  button_menu_fsm #(
    .NUM_ITEMS      (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string tag;
    bit    act;
    int    cur;
    bit    vld;
    int    id;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One stimulus cycle: drive at negedge, queue the outputs expected after
  // the following rising edge.
  task automatic cyc(input bit tp, input bit tn, input bit ts, input bit rdy,
                     input bit ea, input int ec, input bit ev, input int ei,
                     input string tag);
    exp_t e;
    @(negedge clk);
    if (tp) bus.b_prev = ~bus.b_prev;
    if (tn) bus.b_next = ~bus.b_next;
    if (ts) bus.b_sel  = ~bus.b_sel;
    bus.action_ready = rdy;
    e.tag = tag; e.act = ea; e.cur = ec; e.vld = ev; e.id = ei;
    sb.push_back(e);
  endtask

  task automatic quiet(input int n, input bit ea, input int ec, input bit ev,
                       input int ei, input string tag);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, ea, ec, ev, ei, tag);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".menu_active"},  int'(bus.menu_active),  int'(e.act));
      check({e.tag, ".cursor"},       int'(bus.cursor),       e.cur);
      check({e.tag, ".action_valid"}, int'(bus.action_valid), int'(e.vld));
      check({e.tag, ".action_id"},    int'(bus.action_id),    e.id);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus.b_prev = 1'b0;
    bus.b_next = 1'b1;
    bus.b_sel = 1'b0;
    bus.action_ready = 1'b0;
    #1;
    check("reset.menu_active",  int'(bus.menu_active),  0);
    check("reset.cursor",       int'(bus.cursor),       0);
    check("reset.action_valid", int'(bus.action_valid), 0);
    check("reset.action_id",    int'(bus.action_id),    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // b_next held high through reset release must not wake the menu
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "arm_no_event");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "idle_hold");
    cyc(0, 1, 0, 0, 1, 0, 0, 0, "wake_next");

    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, (i + 1) % 4, 0, 0, "next_wrap");
    cyc(1, 0, 0, 0, 1, 0, 0, 0, "prev_down");
    cyc(1, 0, 0, 0, 1, 3, 0, 0, "prev_wrap");
    cyc(0, 1, 0, 0, 1, 0, 0, 0, "next_a");
    cyc(0, 1, 0, 0, 1, 1, 0, 0, "next_b");
    cyc(0, 1, 0, 0, 1, 2, 0, 0, "next_c");

    // select at cursor 2, core stalls; next toggles are dropped
    cyc(0, 0, 1, 0, 1, 2, 1, 2, "sel_pending");
    for (int i = 0; i < 9; i++) cyc(0, i[0], 0, 0, 1, 2, 1, 2, "pending_hold");
    cyc(0, 0, 0, 1, 0, 2, 0, 2, "handshake");
    cyc(0, 0, 0, 0, 0, 2, 0, 2, "idle_after_hs");

    // prev+next together: no move, counter restarts
    cyc(1, 0, 0, 0, 1, 0, 0, 2, "wake_prev");
    cyc(0, 1, 0, 0, 1, 1, 0, 2, "next_to_1");
    quiet(5, 1, 1, 0, 2, "browse_wait");
    cyc(1, 1, 0, 0, 1, 1, 0, 2, "pair_discard");
    quiet(7, 1, 1, 0, 2, "pair_cnt_cleared");
    cyc(0, 0, 0, 0, 0, 1, 0, 2, "pair_timeout");

    // sel+next together, ready already high
    cyc(0, 1, 0, 0, 1, 0, 0, 2, "wake_next2");
    cyc(0, 1, 0, 0, 1, 1, 0, 2, "next_to_1b");
    cyc(0, 1, 1, 1, 1, 1, 1, 1, "sel_plus_next");
    cyc(0, 0, 0, 1, 0, 1, 0, 1, "ready_early");
    cyc(0, 0, 0, 0, 0, 1, 0, 1, "idle_after_early");

    // timeout: menu closes 8 cycles after entry; sel as waking event
    cyc(0, 0, 1, 0, 1, 0, 0, 1, "wake_sel");
    quiet(7, 1, 0, 0, 1, "timeout_open");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, "timeout_8");

    // event on the would-be timeout cycle wins
    cyc(1, 0, 0, 0, 1, 0, 0, 1, "wake_prev2");
    quiet(7, 1, 0, 0, 1, "late_open");
    cyc(0, 1, 0, 0, 1, 1, 0, 1, "late_event");
    quiet(7, 1, 1, 0, 1, "late_reopen");
    cyc(0, 0, 0, 0, 0, 1, 0, 1, "late_timeout");

    // asynchronous reset in PENDING
    cyc(0, 1, 0, 0, 1, 0, 0, 1, "wake_next3");
    cyc(0, 1, 0, 0, 1, 1, 0, 1, "next_to_1c");
    cyc(0, 0, 1, 0, 1, 1, 1, 1, "sel_before_rst");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.menu_active",  int'(bus.menu_active),  0);
    check("async_rst.cursor",       int'(bus.cursor),       0);
    check("async_rst.action_valid", int'(bus.action_valid), 0);
    check("async_rst.action_id",    int'(bus.action_id),    0);
    @(negedge clk);
    bus.b_sel = ~bus.b_sel;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, "post_rst_arm");
    quiet(2, 0, 0, 0, 0, "post_rst_idle");
    cyc(0, 1, 0, 0, 1, 0, 0, 0, "post_rst_wake");

    @(posedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
